// File: rtl/student_mux_pkg.sv
// student_mux_pkg: mode encodings and the rotating priority search shared by
// student_rr_mux and its arbiter. The search supports up to MAX_CHANNELS inputs.
package student_mux_pkg;

  // Mode encoding for the mux select policy.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on channel count handled by the search function.
  localparam int unsigned MAX_CHANNELS = 64;
  localparam int unsigned IDX_W        = 6;

  // Result of a priority search: whether anything was found, and where.
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of valid[0 +: n], scanning start, start+1, ... modulo n.
  // start must be below n.
  function automatic pick_t rr_find_first(
    input logic [MAX_CHANNELS-1:0] valid,
    input int unsigned             n,
    input int unsigned             start
  );
    pick_t       r;
    int unsigned c;
    r = '0;
    for (int unsigned k = 0; k < MAX_CHANNELS; k++) begin
      if (k < n && !r.found) begin
        c = start + k;
        if (c >= n) c = c - n;
        if (valid[c[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/student_rr_arbiter.sv
// student_rr_arbiter: combinational grant for student_rr_mux. In fixed mode the
// selected channel wins if it exists and is valid; in round-robin mode the first
// valid channel at or after rr_ptr (wrapping) wins.
module student_rr_arbiter
  import student_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] in_valid,
  input  logic [SEL_W-1:0]    rr_ptr,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                grant_vld
);

  pick_t rr_pick;

  // Pick the winner for the current mode; an out-of-range sel never matches.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant_idx = '0;
    grant_vld = 1'b0;
    rr_pick   = rr_find_first(MAX_CHANNELS'(in_valid), CHANNELS, 32'(rr_ptr));

    if (mode == MODE_RR) begin
      // The range check also keeps the full index in use for narrow SEL_W.
      grant_vld = rr_pick.found && (32'(rr_pick.idx) < CHANNELS);
      grant_idx = rr_pick.idx[SEL_W-1:0];
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/student_rr_mux.sv
// student_rr_mux: CHANNELS-way WIDTH-bit valid/ready multiplexer with fixed or
// round-robin selection and a one-entry registered output stage.
// Optional statistics (xfer_count, stall) are built when STUDENT_RR_MUX_STATS_EN
// is defined.
module student_rr_mux
  import student_mux_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef STUDENT_RR_MUX_STATS_EN
  ,
  output logic [15:0]               xfer_count,
  output logic                      stall
`endif
);

  logic [WIDTH-1:0] chan_data [CHANNELS];

  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load_en;
  logic             xfer_in;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_chan_q,  out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  // Split the flat input bus into one word per channel.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  student_rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arbiter (
    .in_valid  (in_valid),
    .rr_ptr    (rr_ptr_q),
    .mode      (mode),
    .sel       (sel),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Handshake: accept when the register is empty or draining this cycle.
  always_comb begin
    load_en  = !out_valid_q || out_ready;
    xfer_in  = load_en && grant_vld && !reset;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer_in && (grant_idx == SEL_W'(i));
    end
  end

  // Next state of the output stage and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (xfer_in) begin
      out_data_d  = chan_data[grant_idx];
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_q && out_ready) begin
      // Drain without refill: data and channel keep their last values.
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef STUDENT_RR_MUX_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  logic        stall_q,      stall_d;

  // Count output handshakes (wrapping) and flag cycles held by backpressure.
  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid_q && out_ready) xfer_count_d = xfer_count_q + 16'd1;
    stall_d = out_valid_q && !out_ready;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      xfer_count_q <= xfer_count_d;
      stall_q      <= stall_d;
    end
  end

  assign xfer_count = xfer_count_q;
  assign stall      = stall_q;
`endif

endmodule

// File: tb/tb_student_rr_mux.sv
// tb_student_rr_mux: directed self-checking bench for student_rr_mux.
// A 4-channel instance carries most scenarios; a 3-channel instance covers the
// non-power-of-two boundaries. Statistics checks build with STUDENT_RR_MUX_STATS_EN.
module tb_student_rr_mux;

  logic        clk = 1'b0;
  logic        reset;

  // 4-channel instance
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [15:0] out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  // 3-channel instance
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [15:0] out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

`ifdef STUDENT_RR_MUX_STATS_EN
  logic [15:0] xfer_count, xfer_count3;
  logic        stall, stall3;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] word [4];

  always #5 clk = ~clk;

  student_rr_mux #(.WIDTH(16), .CHANNELS(4)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .sel        (sel),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef STUDENT_RR_MUX_STATS_EN
    ,
    .xfer_count (xfer_count),
    .stall      (stall)
`endif
  );

  student_rr_mux #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data3),
    .in_valid   (in_valid3),
    .in_ready   (in_ready3),
    .mode       (mode3),
    .sel        (sel3),
    .out_data   (out_data3),
    .out_chan   (out_chan3),
    .out_valid  (out_valid3),
    .out_ready  (out_ready3)
`ifdef STUDENT_RR_MUX_STATS_EN
    ,
    .xfer_count (xfer_count3),
    .stall      (stall3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++;
      $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++;
      $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    reset = 1'b0; mode = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++;
      $display("FAIL release_in_ready: got %b expected 0001", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 16'h1234) begin
      errors++;
      $display("FAIL release_first_grant: got v=%b ch=%0d d=%h expected v=1 ch=0 d=1234",
               out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++; if (in_ready !== 4'(1 << s)) begin errors++;
        $display("FAIL fixed_in_ready[%0d]: got %b expected %b", s, in_ready, 4'(1 << s)); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== word[s] || out_chan !== 2'(s)) begin
        errors++;
        $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 s, out_valid, out_chan, out_data, s, word[s]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_all [5]  = '{0, 1, 2, 3, 0};
    int exp_skip [4] = '{2, 3, 0, 2};
    apply_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1; sel = 2'd3;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 4'(1 << exp_all[k])) begin errors++;
        $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'(1 << exp_all[k])); end
      tick();
      checks++; if (out_chan !== 2'(exp_all[k]) || out_data !== word[exp_all[k]]) begin
        errors++;
        $display("FAIL rr_out[%0d]: got ch=%0d d=%h expected ch=%0d d=%h",
                 k, out_chan, out_data, exp_all[k], word[exp_all[k]]);
      end
    end
    in_valid = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (out_chan !== 2'(exp_skip[k]) || out_data !== word[exp_skip[k]]) begin
        errors++;
        $display("FAIL rr_skip[%0d]: got ch=%0d d=%h expected ch=%0d d=%h",
                 k, out_chan, out_data, exp_skip[k], word[exp_skip[k]]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    sel = 2'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin errors++;
        $display("FAIL bp_in_ready[%0d]: got %b expected 0000", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_chan !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=0 d=1234",
                 k, out_valid, out_chan, out_data);
      end
`ifdef STUDENT_RR_MUX_STATS_EN
      checks++; if (stall !== 1'b1) begin errors++;
        $display("FAIL bp_stall[%0d]: got %b expected 1", k, stall); end
`endif
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++;
      $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h9876 || out_chan !== 2'd1) begin
      errors++;
      $display("FAIL bp_next_word: got v=%b ch=%0d d=%h expected v=1 ch=1 d=9876",
               out_valid, out_chan, out_data);
    end
`ifdef STUDENT_RR_MUX_STATS_EN
    checks++; if (stall !== 1'b0) begin errors++;
      $display("FAIL bp_stall_clear: got %b expected 0", stall); end
`endif
    in_valid = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h9876 || out_chan !== 2'd1) begin
      errors++;
      $display("FAIL drain_hold: got v=%b ch=%0d d=%h expected v=0 ch=1 d=9876",
               out_valid, out_chan, out_data);
    end
  endtask

  task automatic test_boundary();
    // Round-robin wrap from channel 3 on the 4-way instance.
    apply_reset();
    mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1000;
    tick();
    in_valid = 4'b1111;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++;
      $display("FAIL rr_wrap4: got %b expected 0001", in_ready); end
    // Fixed-mode transfers leave the pointer alone.
    apply_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
    tick();
    mode = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++;
      $display("FAIL fixed_keeps_ptr: got %b expected 0001", in_ready); end
    // 3-channel instance: sel=3 is out of range.
    apply_reset();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
    #1;
    checks++; if (in_ready3 !== 3'b000) begin errors++;
      $display("FAIL sel_oob_ready: got %b expected 000", in_ready3); end
    tick(); tick();
    checks++; if (out_valid3 !== 1'b0) begin errors++;
      $display("FAIL sel_oob_valid: got %b expected 0", out_valid3); end
    // 3-channel round-robin: pointer wraps from 2 to 0.
    mode3 = 1'b1; in_valid3 = 3'b100;
    tick();
    checks++; if (out_chan3 !== 2'd2 || out_data3 !== 16'hAAAA) begin errors++;
      $display("FAIL rr3_ch2: got ch=%0d d=%h expected ch=2 d=aaaa", out_chan3, out_data3); end
    in_valid3 = 3'b111;
    #1;
    checks++; if (in_ready3 !== 3'b001) begin errors++;
      $display("FAIL rr3_wrap: got %b expected 001", in_ready3); end
    tick();
    checks++; if (out_chan3 !== 2'd0 || out_data3 !== 16'h1234) begin errors++;
      $display("FAIL rr3_after_wrap: got ch=%0d d=%h expected ch=0 d=1234", out_chan3, out_data3); end
    in_valid3 = 3'b000;
    // Reset while full discards the held word.
    mode = 1'b0; sel = 2'd3; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h5555) begin errors++;
      $display("FAIL full_before_reset: got v=%b d=%h expected v=1 d=5555", out_valid, out_data); end
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++;
      $display("FAIL ready_in_reset: got %b expected 0000", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_while_full: got v=%b ch=%0d d=%h expected v=0 ch=0 d=0000",
               out_valid, out_chan, out_data);
    end
    reset = 1'b0;
    in_valid = 4'b0000;
  endtask

`ifdef STUDENT_RR_MUX_STATS_EN
  task automatic test_stats();
    apply_reset();
    checks++; if (xfer_count !== 16'd0) begin errors++;
      $display("FAIL stats_reset: got %0d expected 0", xfer_count); end
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    // The first edge only fills the register; every later edge is a handshake.
    for (int k = 0; k < 70001; k++) tick();
    checks++; if (xfer_count !== 16'd4464) begin errors++;
      $display("FAIL stats_wrap: got %0d expected 4464", xfer_count); end
    in_valid = 4'b0000;
  endtask
`endif

  initial begin
    word[0] = 16'h1234; word[1] = 16'h9876; word[2] = 16'hAAAA; word[3] = 16'h5555;
    in_data    = {word[3], word[2], word[1], word[0]};
    in_data3   = {word[2], word[1], word[0]};
    reset      = 1'b1;
    in_valid   = '0; mode  = 1'b0; sel  = '0; out_ready  = 1'b1;
    in_valid3  = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;

    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_boundary();
`ifdef STUDENT_RR_MUX_STATS_EN
    test_stats();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
